paddle_tracker: RTL and testbench

Multi-channel quadrature-encoder paddle tracker for the Pong datapath. It synchronises and optionally glitch-filters each paddle's A/B encoder pair, decodes it in a per-channel state machine, and maintains a saturating paddle-top position per channel. Positions feed the ball/collision logic and the renderer. It succeeds the single-clock-free two-paddle mover with a clocked, bounded, N-channel design that supports x1 or x4 decoding.

---
 rtl/paddle_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_paddle_tracker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_tracker.sv
// paddle_tracker: N-channel quadrature-encoder paddle tracker.
//   Each channel's A/B pair is 2-flop synchronised (and optionally glitch
//   filtered), decoded by a PRIME/RUN state machine in x1 or x4 mode, and
//   accumulated into a saturating paddle-top position.
// Optional feature: define PADDLE_FILTER_EN to insert a per-bit stability
//   filter (FILT_CYCLES consecutive differing samples) after the synchroniser.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   reset_game - synchronous game restart (active high)
//   enc_a/b    - asynchronous encoder inputs, one bit per channel
//   pos        - packed positions, channel i at [i*POS_W +: POS_W]
//   moved      - one-cycle pulse per applied step
//   dir        - direction of last applied step (1 = +1, 0 = -1)
//   qerr       - sticky illegal-transition flag
module paddle_tracker #(
    parameter int NUM_PADDLES = 2,
    parameter int POS_W       = 6,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 56,
    parameter int POS_INIT    = 28,
    parameter int DECODE      = 1,
    parameter int FILT_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           reset_game,
    input  logic [NUM_PADDLES-1:0]         enc_a,
    input  logic [NUM_PADDLES-1:0]         enc_b,
    output logic [NUM_PADDLES*POS_W-1:0]   pos,
    output logic [NUM_PADDLES-1:0]         moved,
    output logic [NUM_PADDLES-1:0]         dir,
    output logic [NUM_PADDLES-1:0]         qerr
);

    generate
        if (!(POS_MIN >= 0 && POS_MIN <= POS_INIT && POS_INIT <= POS_MAX &&
              POS_MAX < (1 << POS_W))) begin : g_bad_pos
            $error("paddle_tracker: illegal POS_MIN/POS_INIT/POS_MAX/POS_W");
        end
        if (DECODE != 1 && DECODE != 4) begin : g_bad_decode
            $error("paddle_tracker: DECODE must be 1 or 4");
        end
    endgenerate

    localparam logic [POS_W:0]    LP_MAX_X  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]    LP_MIN_X  = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W-1:0]  LP_INIT   = POS_W'(POS_INIT);
    localparam int                LP_NB     = 2 * NUM_PADDLES;

    // Synchroniser: bits [N-1:0] are A, bits [2N-1:N] are B.
    logic [LP_NB-1:0] r_s1, r_s2, w_ab;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {enc_b, enc_a};
            r_s2 <= r_s1;
        end
    end

`ifdef PADDLE_FILTER_EN
    localparam int               LP_CW    = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES);
    localparam logic [LP_CW-1:0] LP_FLAST = LP_CW'(FILT_CYCLES - 1);
    localparam int               LP_FILL  = 2 + FILT_CYCLES;

    logic [LP_NB-1:0] r_filt;
    logic [LP_CW-1:0] r_fcnt [LP_NB];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt <= '0;
            for (int unsigned i = 0; i < LP_NB; i++) r_fcnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < LP_NB; i++) begin
                if (r_s2[i] != r_filt[i]) begin
                    if (r_fcnt[i] == LP_FLAST) begin
                        r_filt[i] <= r_s2[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + 1'b1;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
        end
    end

    assign w_ab = r_filt;
`else
    localparam int LP_FILL = 2;

    assign w_ab = r_s2;
`endif

    // The input pipeline resets to 0, so PRIME is held until it carries real
    // encoder levels; otherwise a paddle parked at 11 would look illegal.
    localparam int                LP_FW   = $clog2(LP_FILL + 1);
    localparam logic [LP_FW-1:0]  LP_FULL = LP_FW'(LP_FILL);

    logic [LP_FW-1:0] r_fill;
    logic             w_filled;

    assign w_filled = (r_fill == LP_FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_fill <= '0;
        else if (!w_filled) r_fill <= r_fill + 1'b1;
    end

    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    state_t          r_state     [NUM_PADDLES];
    state_t          w_state_nxt [NUM_PADDLES];
    logic [1:0]      r_prev      [NUM_PADDLES];
    logic [1:0]      w_cur       [NUM_PADDLES];
    logic [POS_W-1:0] r_pos      [NUM_PADDLES];
    logic [POS_W:0]  w_inc       [NUM_PADDLES];
    logic [POS_W:0]  w_dec       [NUM_PADDLES];
    logic [NUM_PADDLES-1:0] w_up, w_dn, w_ill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PADDLES; i++) r_state[i] <= ST_PRIME;
        end else begin
            for (int unsigned i = 0; i < NUM_PADDLES; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_comb begin
        w_up  = '0;
        w_dn  = '0;
        w_ill = '0;
        for (int unsigned i = 0; i < NUM_PADDLES; i++) begin
            w_cur[i]       = {w_ab[i], w_ab[NUM_PADDLES + i]};
            w_state_nxt[i] = r_state[i];
            w_inc[i]       = {1'b0, r_pos[i]} + 1'b1;
            w_dec[i]       = {1'b0, r_pos[i]} - 1'b1;
            if (reset_game) begin
                w_state_nxt[i] = ST_PRIME;
            end else begin
                case (r_state[i])
                    ST_PRIME: if (w_filled) w_state_nxt[i] = ST_RUN;
                    ST_RUN: begin
                        w_ill[i] = &(r_prev[i] ^ w_cur[i]);
                        if (DECODE == 4) begin
                            case ({r_prev[i], w_cur[i]})
                                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up[i] = 1'b1;
                                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_dn[i] = 1'b1;
                                default: ;
                            endcase
                        end else begin
                            w_up[i] = (r_prev[i] == 2'b00) && (w_cur[i] == 2'b10);
                            w_dn[i] = (r_prev[i] == 2'b00) && (w_cur[i] == 2'b01);
                        end
                    end
                    default: w_state_nxt[i] = ST_PRIME;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            moved <= '0;
            dir   <= '0;
            qerr  <= '0;
            for (int unsigned i = 0; i < NUM_PADDLES; i++) begin
                r_pos[i]  <= LP_INIT;
                r_prev[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PADDLES; i++) begin
                moved[i]  <= 1'b0;
                r_prev[i] <= w_cur[i];
                if (reset_game) begin
                    r_pos[i] <= LP_INIT;
                    qerr[i]  <= 1'b0;
                end else begin
                    if (w_ill[i]) qerr[i] <= 1'b1;
                    if (w_up[i] && (w_inc[i] <= LP_MAX_X)) begin
                        r_pos[i] <= w_inc[i][POS_W-1:0];
                        moved[i] <= 1'b1;
                        dir[i]   <= 1'b1;
                    end else if (w_dn[i] && ({1'b0, r_pos[i]} > LP_MIN_X)) begin
                        r_pos[i] <= w_dec[i][POS_W-1:0];
                        moved[i] <= 1'b1;
                        dir[i]   <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        pos = '0;
        for (int unsigned i = 0; i < NUM_PADDLES; i++) pos[i*POS_W +: POS_W] = r_pos[i];
    end

endmodule

// File: tb/tb_paddle_tracker.sv
// tb_paddle_tracker: randomized + directed bench for paddle_tracker.
//   Two instances (x1 and x4 decode) share the encoder inputs; a phase-based
//   reference model tracks expected positions, qerr, pulse counts and dir.
module tb_paddle_tracker;
    localparam int NP    = 2;
    localparam int PW    = 6;
    localparam int PMAX  = 56;
    localparam int PINIT = 28;

    logic clk = 1'b0;
    logic reset, reset_game;
    logic [NP-1:0] enc_a, enc_b;
    logic [NP*PW-1:0] pos_x1, pos_x4;
    logic [NP-1:0] mov_x1, mov_x4, dir_x1, dir_x4, qerr_x1, qerr_x4;

    always #5 clk = ~clk;

    paddle_tracker #(.NUM_PADDLES(NP), .POS_W(PW), .POS_MIN(0), .POS_MAX(PMAX),
                     .POS_INIT(PINIT), .DECODE(1), .FILT_CYCLES(4)) u_x1 (
        .clk(clk), .reset(reset), .reset_game(reset_game), .enc_a(enc_a), .enc_b(enc_b),
        .pos(pos_x1), .moved(mov_x1), .dir(dir_x1), .qerr(qerr_x1));

    paddle_tracker #(.NUM_PADDLES(NP), .POS_W(PW), .POS_MIN(0), .POS_MAX(PMAX),
                     .POS_INIT(PINIT), .DECODE(4), .FILT_CYCLES(4)) u_x4 (
        .clk(clk), .reset(reset), .reset_game(reset_game), .enc_a(enc_a), .enc_b(enc_b),
        .pos(pos_x4), .moved(mov_x4), .dir(dir_x4), .qerr(qerr_x4));

    int n_chk  = 0;
    int n_pass = 0;

    // Model state, index [decoder 0=x1 1=x4][channel]
    int m_pos [2][NP];
    int m_mov [2][NP];
    int m_dir [2][NP];
    int m_q   [2][NP];
    int c_mov [2][NP];
    int c_dir [2][NP];
    bit g_hold = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Pulse monitor, sampled well after the active edge.
    always @(posedge clk) begin
        #2;
        for (int ch = 0; ch < NP; ch++) begin
            if (mov_x1[ch]) begin c_mov[0][ch]++; c_dir[0][ch] = int'(dir_x1[ch]); end
            if (mov_x4[ch]) begin c_mov[1][ch]++; c_dir[1][ch] = int'(dir_x4[ch]); end
        end
    end

    // Position in the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic int phase(input bit a, input bit b);
        if (a) return b ? 2 : 1;
        return b ? 3 : 0;
    endfunction

    task automatic model_update(input int ch, input bit oa, input bit ob, input bit na, input bit nb);
        int op, np, dl, st;
        op = phase(oa, ob);
        np = phase(na, nb);
        dl = (np - op + 4) % 4;
        if (g_hold) return;
        for (int d = 0; d < 2; d++) begin
            st = 0;
            if (dl == 2) m_q[d][ch] = 1;
            else if (dl == 1 && (d == 1 || op == 0)) st = 1;
            else if (dl == 3 && (d == 1 || op == 0)) st = -1;
            if (st == 1 && m_pos[d][ch] < PMAX) begin
                m_pos[d][ch]++; m_mov[d][ch]++; m_dir[d][ch] = 1;
            end else if (st == -1 && m_pos[d][ch] > 0) begin
                m_pos[d][ch]--; m_mov[d][ch]++; m_dir[d][ch] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int obs_pos, obs_q;
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < NP; ch++) begin
                obs_pos = (d == 1) ? int'(pos_x4[ch*PW +: PW]) : int'(pos_x1[ch*PW +: PW]);
                obs_q   = (d == 1) ? int'(qerr_x4[ch]) : int'(qerr_x1[ch]);
                check_eq($sformatf("%s/x%0d/ch%0d/pos", tag, d ? 4 : 1, ch), obs_pos, m_pos[d][ch]);
                check_eq($sformatf("%s/x%0d/ch%0d/qerr", tag, d ? 4 : 1, ch), obs_q, m_q[d][ch]);
                check_eq($sformatf("%s/x%0d/ch%0d/moves", tag, d ? 4 : 1, ch), c_mov[d][ch], m_mov[d][ch]);
                if (m_mov[d][ch] > 0)
                    check_eq($sformatf("%s/x%0d/ch%0d/dir", tag, d ? 4 : 1, ch), c_dir[d][ch], m_dir[d][ch]);
            end
        end
    endtask

    task automatic drive(input logic [NP-1:0] na, input logic [NP-1:0] nb, input string tag);
        for (int ch = 0; ch < NP; ch++) model_update(ch, enc_a[ch], enc_b[ch], na[ch], nb[ch]);
        enc_a = na;
        enc_b = nb;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_ch(input int ch, input bit a, input bit b, input string tag);
        logic [NP-1:0] na, nb;
        na = enc_a; nb = enc_b;
        na[ch] = a; nb[ch] = b;
        drive(na, nb, tag);
    endtask

    // Move channel ch one quadrature phase: dn = +1 forward, -1 reverse, 2 illegal.
    task automatic step_ch(input int ch, input int dn, input string tag);
        logic [1:0] ab_of [4];
        logic [1:0] ab;
        int p;
        ab_of[0] = 2'b00; ab_of[1] = 2'b10; ab_of[2] = 2'b11; ab_of[3] = 2'b01;
        p  = (phase(enc_a[ch], enc_b[ch]) + dn + 4) % 4;
        ab = ab_of[p];
        set_ch(ch, ab[1], ab[0], tag);
    endtask

    task automatic model_game();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < NP; ch++) begin
                m_pos[d][ch] = PINIT;
                m_q[d][ch]   = 0;
            end
    endtask

    task automatic game_pulse(input string tag);
        reset_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_game = 1'b0;
        model_game();
        check_all(tag);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [NP-1:0] na, nb;
        int r, p, k;
        reset      = 1'b0;
        reset_game = 1'b0;
        enc_a      = 2'b01;   // channel 0 parked at 11 through reset
        enc_b      = 2'b01;
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < NP; ch++) begin
                m_pos[d][ch] = PINIT; m_mov[d][ch] = 0; m_dir[d][ch] = 0;
                m_q[d][ch]   = 0;     c_mov[d][ch] = 0; c_dir[d][ch] = 0;
            end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset/dir_x1", int'(dir_x1), 0);
        check_eq("reset/moved_x4", int'(mov_x4), 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_all("reset");

        // Bring channel 0 to 00 going forward, then 3 full forward cycles.
        step_ch(0, 1, "prep0");
        step_ch(0, 1, "prep0");
        for (int n = 0; n < 12; n++) step_ch(0, 1, "fwd3");
        check_eq("fwd3/x1/pos0", int'(pos_x1[0 +: PW]), 31);
        check_eq("fwd3/x1/pos1", int'(pos_x1[PW +: PW]), 28);

        // 8 reverse edges on channel 1.
        for (int n = 0; n < 8; n++) step_ch(1, -1, "rev8");
        check_eq("rev8/x4/pos1", int'(pos_x4[PW +: PW]), 20);

        // Saturation at both bounds.
        for (int n = 0; n < 160; n++) step_ch(0, 1, "satup");
        check_eq("satup/x1/pos0", int'(pos_x1[0 +: PW]), PMAX);
        check_eq("satup/x4/pos0", int'(pos_x4[0 +: PW]), PMAX);
        for (int n = 0; n < 280; n++) step_ch(0, -1, "satdn");
        check_eq("satdn/x1/pos0", int'(pos_x1[0 +: PW]), 0);
        check_eq("satdn/x4/pos0", int'(pos_x4[0 +: PW]), 0);

        // Illegal jump 00 -> 11, then game restart, then one forward count.
        set_ch(0, 1'b0, 1'b0, "ill_pre");
        set_ch(0, 1'b1, 1'b1, "ill");
        check_eq("ill/x1/qerr0", int'(qerr_x1[0]), 1);
        game_pulse("game");
        check_eq("game/x1/pos0", int'(pos_x1[0 +: PW]), PINIT);
        step_ch(0, 1, "post");
        step_ch(0, 1, "post");
        step_ch(0, 1, "post");
        check_eq("post/x1/pos0", int'(pos_x1[0 +: PW]), 29);

        // reset_game held while encoders keep moving.
        reset_game = 1'b1;
        g_hold     = 1'b1;
        model_game();
        for (int n = 0; n < 4; n++) begin
            na = enc_a; nb = enc_b;
            drive(~na ^ nb, na, "hold");
            step_ch(1, 1, "hold");
        end
        reset_game = 1'b0;
        g_hold     = 1'b0;
        repeat (2) @(negedge clk);

        // Random traffic on both channels.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                game_pulse("rgame");
            end else begin
                na = enc_a; nb = enc_b;
                for (int ch = 0; ch < NP; ch++) begin
                    if ($urandom_range(0, 2) != 0) begin
                        k = $urandom_range(0, 15);
                        p = phase(na[ch], nb[ch]);
                        if (k == 0)      p = (p + 2) % 4;
                        else if (k < 9)  p = (p + 1) % 4;
                        else             p = (p + 3) % 4;
                        na[ch] = (p == 1 || p == 2);
                        nb[ch] = (p == 2 || p == 3);
                    end
                end
                drive(na, nb, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
